// File: rtl/gpr_pkg.sv
// Shared writeback definitions for the GPR write port and its producers
// (WB stage, mult/div unit).
package gpr_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/gpr_starve_guard.sv
// Saturating wait counter for a low-priority port.
// Raises force_o once the port has waited STARVE_LIMIT consecutive valid cycles.
module gpr_starve_guard #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid_i,
  input  logic grant_i,
  output logic force_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign force_o = req_valid_i && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (!req_valid_i || grant_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Two-source arbiter for the single GPR write port: port 0 has priority,
// port 1 is protected from starvation. Registered write plus read forwarding.
module gpr_wb_arbiter #(
  parameter int DATA_W       = gpr_pkg::DATA_W,
  parameter int ADDR_W       = gpr_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [DATA_W-1:0]      req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [DATA_W-1:0]      req1_data,
  output logic                   req1_ready,
  output logic                   regWrite,
  output logic [ADDR_W-1:0]      rw,
  output logic [DATA_W-1:0]      Wd,
  input  logic [ADDR_W-1:0]      q_rs,
  input  logic [ADDR_W-1:0]      q_rt,
  output logic                   fwd_rs_hit,
  output logic                   fwd_rt_hit,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(gpr_pkg::ZERO_REG);

  logic force_grant, grant1;
  logic hs0, hs1;

  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      rw_q, rw_d;
  logic [DATA_W-1:0]      wd_q, wd_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  gpr_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_guard (
    .clk        (clk),
    .reset      (reset),
    .req_valid_i(req1_valid),
    .grant_i    (grant1),
    .force_o    (force_grant)
  );

  assign grant1 = force_grant || (req1_valid && !req0_valid);

  // Readies are held low during reset so nothing handshakes into a clearing pipe.
  assign req0_ready = reset && !force_grant;
  assign req1_ready = reset && grant1;

  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;

  always_comb begin
    we_d    = 1'b0;
    rw_d    = rw_q;
    wd_d    = wd_q;
    stall_d = stall_q;
    if (hs0) begin
      we_d = (req0_addr != ZERO_ADDR);
      rw_d = req0_addr;
      wd_d = req0_data;
    end else if (hs1) begin
      we_d = (req1_addr != ZERO_ADDR);
      rw_d = req1_addr;
      wd_d = req1_data;
    end
    if (req0_valid && !req0_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      rw_q    <= '0;
      wd_q    <= '0;
      stall_q <= '0;
    end else begin
      we_q    <= we_d;
      rw_q    <= rw_d;
      wd_q    <= wd_d;
      stall_q <= stall_d;
    end
  end

  assign regWrite   = we_q;
  assign rw         = rw_q;
  assign Wd         = wd_q;
  assign stall_cnt  = stall_q;
  assign fwd_rs_hit = we_q && (rw_q == q_rs);
  assign fwd_rt_hit = we_q && (rw_q == q_rt);
  assign fwd_data   = wd_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: default instance plus a small-counter
// instance for stall-count saturation.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        regWrite;
  logic [4:0]  rw;
  logic [31:0] Wd;
  logic [4:0]  q_rs, q_rt;
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [31:0] fwd_data;
  logic [15:0] stall_cnt;

  logic        s_req0_valid, s_req1_valid;
  logic [4:0]  s_addr0, s_addr1, s_q_rs, s_q_rt;
  logic [31:0] s_data0, s_data1;
  logic        s_req0_ready, s_req1_ready, s_regWrite, s_rs_hit, s_rt_hit;
  logic [4:0]  s_rw;
  logic [31:0] s_Wd, s_fwd_data;
  logic [3:0]  s_stall_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .regWrite(regWrite), .rw(rw), .Wd(Wd),
    .q_rs(q_rs), .q_rt(q_rt), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .fwd_data(fwd_data), .stall_cnt(stall_cnt)
  );

  gpr_wb_arbiter #(.STARVE_LIMIT(1), .STALL_CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .req0_valid(s_req0_valid), .req0_addr(s_addr0), .req0_data(s_data0), .req0_ready(s_req0_ready),
    .req1_valid(s_req1_valid), .req1_addr(s_addr1), .req1_data(s_data1), .req1_ready(s_req1_ready),
    .regWrite(s_regWrite), .rw(s_rw), .Wd(s_Wd),
    .q_rs(s_q_rs), .q_rt(s_q_rt), .fwd_rs_hit(s_rs_hit), .fwd_rt_hit(s_rt_hit),
    .fwd_data(s_fwd_data), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    q_rs = 0; q_rt = 0;
    s_req0_valid = 0; s_req1_valid = 0;
    s_addr0 = 5'd1; s_addr1 = 5'd2; s_data0 = 32'h11; s_data1 = 32'h22;
    s_q_rs = 0; s_q_rt = 0;

    // reset held two cycles, then released idle
    tick(); tick();
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_regwrite", regWrite, 0);
    reset = 1'b1;
    #1;
    check("idle_ready0", req0_ready, 1);
    check("idle_ready1", req1_ready, 0);
    check("idle_rw", rw, 0);
    check("idle_wd", Wd, 0);
    check("idle_stall", stall_cnt, 0);
    check("idle_starve", dut.u_guard.cnt_q, 0);

    // single port-0 write and forwarding
    req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    check("w0_ready0", req0_ready, 1);
    check("w0_ready1", req1_ready, 0);
    tick();
    req0_valid = 0; q_rs = 5'd5; q_rt = 5'd6;
    #1;
    check("w0_regwrite", regWrite, 1);
    check("w0_rw", rw, 5);
    check("w0_wd", Wd, 32'hDEADBEEF);
    check("w0_rs_hit", fwd_rs_hit, 1);
    check("w0_rt_hit", fwd_rt_hit, 0);
    check("w0_fwd_data", fwd_data, 32'hDEADBEEF);
    tick();
    check("w0_idle_we", regWrite, 0);
    check("w0_hold_rw", rw, 5);
    check("w0_no_hit", fwd_rs_hit, 0);

    // continuous contention: port 1 forced on its 5th valid cycle
    req0_valid = 1; req0_addr = 5'd3; req0_data = 32'hA0A0A0A0;
    req1_valid = 1; req1_addr = 5'd9; req1_data = 32'h99;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check("st_ready0", req0_ready, (i != 5));
      check("st_ready1", req1_ready, (i == 5));
      tick();
      check("st_rw", rw, (i == 5) ? 9 : 3);
    end
    check("st_stall", stall_cnt, 1);
    check("st_regwrite", regWrite, 1);
    check("st_wd", Wd, 32'h99);
    check("st_starve_clr", dut.u_guard.cnt_q, 0);

    // port 1 withdraws before being granted
    tick(); tick();
    check("wd_starve2", dut.u_guard.cnt_q, 2);
    req1_valid = 0;
    tick();
    check("wd_starve0", dut.u_guard.cnt_q, 0);
    check("wd_rw", rw, 3);
    req0_valid = 0;
    tick();
    check("wd_idle_we", regWrite, 0);
    check("wd_stall", stall_cnt, 1);

    // port-1 write to register zero
    req1_valid = 1; req1_addr = 5'd0; req1_data = 32'h1234;
    #1;
    check("z_ready1", req1_ready, 1);
    tick();
    req1_valid = 0; q_rs = 5'd0;
    #1;
    check("z_regwrite", regWrite, 0);
    check("z_rs_hit", fwd_rs_hit, 0);
    check("z_wd", Wd, 32'h1234);
    check("z_rw", rw, 0);

    // reset pulsed during an accepted write with starve count pending
    req0_valid = 1; req0_addr = 5'd3; req1_valid = 1; req1_addr = 5'd4;
    tick(); tick();
    check("rp_starve2", dut.u_guard.cnt_q, 2);
    req0_addr = 5'd7; req0_data = 32'h77; reset = 1'b0;
    #1;
    check("rp_ready0", req0_ready, 0);
    tick();
    reset = 1'b1; req0_valid = 0; req1_valid = 0;
    #1;
    check("rp_regwrite", regWrite, 0);
    check("rp_stall", stall_cnt, 0);
    check("rp_starve", dut.u_guard.cnt_q, 0);
    check("rp_rw", rw, 0);

    // STARVE_LIMIT=1: port 0 stalls every other cycle; 4-bit count must saturate
    s_req0_valid = 1; s_req1_valid = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      check("sat_stall", s_stall_cnt, ((i / 2) > 15) ? 15 : (i / 2));
    end
    s_req0_valid = 0; s_req1_valid = 0;
    tick();
    check("sat_final", s_stall_cnt, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
